// File: rtl/hex_parser_if.sv
// rtl/hex_parser_if.sv - character-in / value-out handshake bundle for hex_parser
interface hex_parser_if #(
    parameter int DIGITS = 4
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [4*DIGITS-1:0] value;
    logic                value_valid;
    logic                value_ready;
    logic [3:0]          digits;
    logic                error;

    modport master (
        output rx_data, rx_valid, value_ready,
        input  rx_ready, value, value_valid, digits, error
    );

    modport slave (
        input  rx_data, rx_valid, value_ready,
        output rx_ready, value, value_valid, digits, error
    );
endinterface

// File: rtl/hex_parser.sv
// rtl/hex_parser.sv - ASCII hex token parser producing right-aligned binary values
module hex_parser #(
    parameter int DIGITS = 4
) (
    input logic        clk,
    input logic        reset,
    hex_parser_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD, EMIT} state_t;

    state_t         state, state_n;
    logic [W-1:0]   acc, acc_n, value_r, value_n;
    logic [3:0]     cnt, cnt_n, digits_r, digits_n;
    logic           error_r, error_n;
    logic           is_hex, is_term, take;
    logic [3:0]     nib;

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'd0;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nib    = bus.rx_data[3:0];
        end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                     (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            is_hex = 1'b1;
            nib    = bus.rx_data[3:0] + 4'd9;
        end
        is_term = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A) ||
                  (bus.rx_data == 8'h20) || (bus.rx_data == 8'h2C);
    end

    assign take = bus.rx_valid && (state != EMIT);

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        value_n  = value_r;
        digits_n = digits_r;
        error_n  = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    if (is_hex) begin
                        acc_n   = W'(nib);
                        cnt_n   = 4'd1;
                        state_n = ACCUM;
                    end else if (!is_term) begin
                        error_n = 1'b1;
                        state_n = DISCARD;
                    end
                end
            end
            ACCUM: begin
                if (take) begin
                    if (is_hex) begin
                        if (cnt == 4'(DIGITS)) begin
                            error_n = 1'b1;
                            state_n = DISCARD;
                        end else begin
                            acc_n = W'({acc, nib});
                            cnt_n = cnt + 4'd1;
                        end
                    end else if (is_term) begin
                        value_n  = acc;
                        digits_n = cnt;
                        state_n  = EMIT;
                    end else begin
                        error_n = 1'b1;
                        state_n = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (take && is_term) begin
                    state_n = IDLE;
                end
            end
            EMIT: begin
                if (bus.value_ready) begin
                    acc_n   = '0;
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= 4'd0;
            value_r  <= '0;
            digits_r <= 4'd0;
            error_r  <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            value_r  <= value_n;
            digits_r <= digits_n;
            error_r  <= error_n;
        end
    end

    // Handshake outputs come straight from the state register so reset drops them at once
    assign bus.rx_ready    = (state != EMIT);
    assign bus.value_valid = (state == EMIT);
    assign bus.value       = value_r;
    assign bus.digits      = digits_r;
    assign bus.error       = error_r;
endmodule

// File: doc/hex_parser.md
# hex_parser

Converts a stream of ASCII characters into binary values by parsing hexadecimal tokens, the inverse of the nibble-to-ASCII path used for display output. It sits between the serial receive path and the debug/monitor command logic, turning typed strings such as "1F3A\r" into parallel values. Input and output both use a valid/ready handshake. Malformed tokens are flagged and discarded.

## Interface
Parameters:
- DIGITS, 4: maximum hex digits per token, legal range 1..8. Output value width is 4*DIGITS.

Ports:
- clk, in, 1: sole clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- rx_data, in, 8: ASCII character.
- rx_valid, in, 1: rx_data is valid.
- rx_ready, out, 1: parser accepts a character; a transfer occurs on rx_valid && rx_ready at a clk edge.
- value, out, 4*DIGITS: parsed token, right-aligned and zero-extended.
- value_valid, out, 1: value and digits hold a completed token.
- value_ready, in, 1: consumer accepts value; a transfer occurs on value_valid && value_ready.
- digits, out, 4: number of hex digits in the emitted token, 1..DIGITS.
- error, out, 1: one-cycle pulse flagging a malformed token.

## Operation
- Character classes:
  - Hex digit: 0x30-0x39, 0x41-0x46, 0x61-0x66 (case-insensitive).
  - Terminator: 0x0D CR, 0x0A LF, 0x20 space, 0x2C comma.
  - Everything else is illegal.
- States: IDLE, ACCUM, DISCARD, EMIT. Reset state is IDLE.
- IDLE:
  - Terminator: ignored, so empty tokens produce no output.
  - Hex digit: acc = digit, cnt = 1, go to ACCUM.
  - Illegal character: pulse error, go to DISCARD.
- ACCUM:
  - Hex digit with cnt < DIGITS: acc = {acc[4*DIGITS-5:0], digit}, cnt = cnt+1.
  - Hex digit with cnt == DIGITS (overflow): pulse error, go to DISCARD.
  - Illegal character: pulse error, go to DISCARD.
  - Terminator: load value = acc and digits = cnt, go to EMIT.
- DISCARD:
  - All non-terminators are consumed silently, with no further error pulses.
  - Terminator: go to IDLE. No value is emitted.
- EMIT:
  - value_valid = 1 and rx_ready = 0.
  - On value_ready: go to IDLE and clear acc and cnt.
  - value and digits stay stable until the transfer completes.
- rx_ready = (state != EMIT). It is decoded from the state register, with no combinational path from rx_valid or value_ready.
- value and digits hold their last emitted contents after a transfer. Only value_valid qualifies them.

## Timing
- Reset values:
  - rx_ready = 1.
  - value = 0, value_valid = 0, digits = 0, error = 0.
  - Internal acc, cnt and state are cleared.
- Reset mid-token or during EMIT:
  - The pending token is lost and value_valid drops asynchronously.
  - No error is raised.
- One character is accepted per cycle at most, with no bubbles between consecutive characters.
- Latency:
  - value_valid rises on the edge that accepts the terminator. It is visible in the following cycle.
  - error is high for exactly the one cycle following the edge that accepted the offending character.
- value_ready may already be high when value_valid rises. The transfer then happens at the next edge, and rx_ready returns high in the cycle after that.
- Minimum token period is digit-count + 2 cycles: digits, then the terminator, then the EMIT cycle.
- Back-pressure:
  - While in EMIT, the upstream must hold rx_data/rx_valid.
  - The held character is consumed only after EMIT exits; nothing is dropped.
- value_ready is ignored when value_valid is 0.

## Test plan
- DIGITS=4, send "1F\r" with value_ready=1 -> one transfer of value=0x001F, digits=2; error never asserts.
- Send "abCD " -> value=0xABCD, digits=4. Then send "\r\r , " -> no value_valid and no error.
- Send "12345\r" -> error pulses once, one cycle after '5' is accepted; no value is emitted. Then send "7\n" -> value=0x0007, digits=1.
- Send "G1,x9\r" -> 'G' gives an error pulse and the token is discarded at ','. 'x' gives a second error pulse and that token is discarded at '\r'. No values are emitted.
- Send "A\r" followed by "B\r", with value_ready held low for 6 cycles after value_valid rises:
  - rx_ready stays low and 'B' is held by the source.
  - value stays 0x000A.
  - After value_ready is asserted, the next token yields 0x000B.
  - No characters are lost.
- Send "12" then assert reset for 1 cycle, then send "3\r" -> value=0x0003, digits=1; no error pulse; all outputs are at their reset values during reset.
